// File: rtl/nandn_deglitch_pkg.sv
// Shared types and defaults for the NAND-N deglitch filter.
// The input synchroniser depth is used only when NANDN_DEGLITCH_SYNC_EN is defined.
package nandn_deglitch_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        QUAL   = 1'b1
    } state_e;

    localparam int DEF_N       = 2;
    localparam int DEF_FILT_W  = 4;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/nandn_sync.sv
// Multi-flop synchroniser for the NAND operands; every stage resets to 0.
// Instantiated by nandn_deglitch only when NANDN_DEGLITCH_SYNC_EN is defined.
module nandn_sync
    import nandn_deglitch_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [SYNC_STAGES*W-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[(SYNC_STAGES-1)*W-1:0], d_i};
        end
    end

    assign q_o = chain_q[SYNC_STAGES*W-1 -: W];

endmodule

// File: rtl/nandn_deglitch.sv
// N-input NAND with a qualification filter on its output and edge pulses.
// Defining NANDN_DEGLITCH_SYNC_EN adds a two-flop synchroniser on every input bit.
module nandn_deglitch
    import nandn_deglitch_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int FILT_W = DEF_FILT_W
) (
    input  logic              CELCLK,
    input  logic              CELRSTN,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic [N-1:0]      i,
    input  logic [FILT_W-1:0] thr,
    input  logic              blank,
    output logic              o,
    output logic              rise,
    output logic              fall,
    output logic              qual
);

    logic [N-1:0] in_s;

`ifdef NANDN_DEGLITCH_SYNC_EN
    nandn_sync #(
        .W (N)
    ) u_sync (
        .clk_i  (CELCLK),
        .rst_ni (CELRSTN),
        .d_i    (i),
        .q_o    (in_s)
    );
`else
    assign in_s = i;
`endif

    // Supply/substrate ties only exist for the cell netlist.
    logic unused_ties;
    assign unused_ties = ^{CELV, CELG, SUB};

    logic raw;
    assign raw = ~&in_s;

    state_e            state_q, state_d;
    logic              s0_q;
    logic              o_q, o_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic [FILT_W-1:0] thr_eff;
    logic [FILT_W-1:0] thr_last;
    logic              mismatch;

    assign thr_eff  = (thr == '0) ? FILT_W'(1) : thr;
    assign thr_last = thr_eff - FILT_W'(1);
    assign mismatch = s0_q ^ o_q;

    // ">=" lets a lowered threshold release o on the next mismatched edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        if (blank) begin
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                STABLE: begin
                    if (mismatch) begin
                        if (thr_last == '0) begin
                            o_d = ~o_q;
                        end else begin
                            cnt_d   = FILT_W'(1);
                            state_d = QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (!mismatch) begin
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q >= thr_last) begin
                        o_d     = ~o_q;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + FILT_W'(1);
                    end
                end
            endcase
        end
    end

    assign rise_d = o_d & ~o_q;
    assign fall_d = ~o_d & o_q;

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_q <= STABLE;
            s0_q    <= 1'b1;
            o_q     <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q    <= raw;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o    = o_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign qual = (state_q == QUAL);

endmodule

// File: tb/tb_nandn_deglitch.sv
// Scoreboard bench for nandn_deglitch: run-length reference model plus directed edge counts.
// Honours NANDN_DEGLITCH_SYNC_EN by adding two cycles of input latency to the model.
module tb_nandn_deglitch;

    localparam int N  = 4;
    localparam int FW = 4;
`ifdef NANDN_DEGLITCH_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          CELCLK = 1'b0;
    logic          CELRSTN;
    logic          CELV;
    logic          CELG;
    logic          SUB;
    logic [N-1:0]  i;
    logic [FW-1:0] thr;
    logic          blank;
    logic          o;
    logic          rise;
    logic          fall;
    logic          qual;

    typedef struct packed {
        logic o;
        logic rise;
        logic fall;
        logic qual;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int mon_cyc  = 0;
    int fall_cnt = 0;
    int rise_cnt = 0;
    int qual_cnt = 0;
    int last_fall = 0;
    int last_rise = 0;

    // Reference: o flips once the delayed raw value has disagreed with it
    // on thr_eff consecutive unblanked edges.
    bit m_o;
    int m_run;
    bit m_pipe[$];

    int t0, f0, r0, q0, len, sel;
    logic [N-1:0]  rnd_i;
    logic [FW-1:0] rnd_thr;
    logic          rnd_blank;

    always #5 CELCLK = ~CELCLK;

    nandn_deglitch #(
        .N      (N),
        .FILT_W (FW)
    ) dut (
        .CELCLK  (CELCLK),
        .CELRSTN (CELRSTN),
        .CELV    (CELV),
        .CELG    (CELG),
        .SUB     (SUB),
        .i       (i),
        .thr     (thr),
        .blank   (blank),
        .o       (o),
        .rise    (rise),
        .fall    (fall),
        .qual    (qual)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_o   = 1'b1;
        m_run = 0;
        m_pipe.delete();
        repeat (LAT) m_pipe.push_back(1'b1);
    endtask

    task automatic model_edge(input logic [N-1:0] iv, input logic [FW-1:0] tv,
                              input logic bv, output exp_t e);
        int te;
        bit prev;
        te   = (tv == 0) ? 1 : int'(tv);
        prev = m_o;
        if (bv) begin
            m_run = 0;
        end else if (m_pipe[0] != m_o) begin
            m_run++;
            if (m_run >= te) begin
                m_o   = ~m_o;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_pipe.push_back(~&iv);
        void'(m_pipe.pop_front());
        e.o    = m_o;
        e.rise = m_o & ~prev;
        e.fall = ~m_o & prev;
        e.qual = (m_run != 0);
    endtask

    // Entered and left just after a falling edge.
    task automatic step(input logic [N-1:0] iv, input logic [FW-1:0] tv,
                        input logic bv);
        exp_t e;
        i     = iv;
        thr   = tv;
        blank = bv;
        model_edge(iv, tv, bv, e);
        exp_q.push_back(e);
        @(negedge CELCLK);
        #1;
    endtask

    task automatic hold(input logic [N-1:0] iv, input logic [FW-1:0] tv,
                        input logic bv, input int n);
        repeat (n) step(iv, tv, bv);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_o"}, 32'(o), 32'd1);
        check({tag, "_rise"}, 32'(rise), 32'd0);
        check({tag, "_fall"}, 32'(fall), 32'd0);
        check({tag, "_qual"}, 32'(qual), 32'd0);
    endtask

    always @(negedge CELCLK) begin
        exp_t e;
        mon_cyc++;
        if (CELRSTN) begin
            if (rise === 1'b1) begin
                rise_cnt++;
                last_rise = mon_cyc;
            end
            if (fall === 1'b1) begin
                fall_cnt++;
                last_fall = mon_cyc;
            end
            if (qual === 1'b1) qual_cnt++;
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_o", 32'(o), 32'(e.o));
            check("sb_rise", 32'(rise), 32'(e.rise));
            check("sb_fall", 32'(fall), 32'(e.fall));
            check("sb_qual", 32'(qual), 32'(e.qual));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CELRSTN = 1'b0;
        CELV    = 1'b1;
        CELG    = 1'b0;
        SUB     = 1'b0;
        i       = '0;
        thr     = 4'd3;
        blank   = 1'b0;
        model_reset();

        repeat (3) begin
            @(negedge CELCLK);
            #1;
            check_idle("reset");
        end
        CELRSTN = 1'b1;
        hold(4'h0, 4'd3, 1'b0, 6);

        t0 = mon_cyc; f0 = fall_cnt; q0 = qual_cnt;
        hold(4'hF, 4'd3, 1'b0, 8);
        check("step_fall_edge", 32'(last_fall - t0), 32'(3 + LAT));
        check("step_fall_count", 32'(fall_cnt - f0), 32'd1);
        check("step_qual_cycles", 32'(qual_cnt - q0), 32'd2);
        t0 = mon_cyc;
        hold(4'h0, 4'd3, 1'b0, 8);
        check("step_rise_edge", 32'(last_rise - t0), 32'(3 + LAT));

        f0 = fall_cnt; r0 = rise_cnt; q0 = qual_cnt;
        hold(4'hF, 4'd3, 1'b0, 2);
        hold(4'h0, 4'd3, 1'b0, 8);
        check("glitch_fall_count", 32'(fall_cnt - f0), 32'd0);
        check("glitch_rise_count", 32'(rise_cnt - r0), 32'd0);
        check("glitch_qual_cycles", 32'(qual_cnt - q0), 32'd2);

        f0 = fall_cnt;
        hold(4'hF, 4'd3, 1'b1, 10);
        check("blank_fall_count", 32'(fall_cnt - f0), 32'd0);
        t0 = mon_cyc;
        hold(4'hF, 4'd3, 1'b0, 6);
        check("unblank_fall_edge", 32'(last_fall - t0), 32'd3);
        hold(4'h0, 4'd3, 1'b0, 8);

        hold(4'h0, 4'd0, 1'b0, 2);
        t0 = mon_cyc;
        hold(4'hF, 4'd0, 1'b0, 6);
        check("thr0_fall_edge", 32'(last_fall - t0), 32'(1 + LAT));
        hold(4'h0, 4'd0, 1'b0, 6);

        hold(4'h0, 4'd5, 1'b0, 2);
        hold(4'hF, 4'd5, 1'b0, 2 + LAT);
        check("midqual_qual", 32'(qual), 32'd1);
        #2;
        CELRSTN = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge CELCLK);
        #1;
        check_idle("rst_hold");
        CELRSTN = 1'b1;
        model_reset();
        r0 = rise_cnt; f0 = fall_cnt; t0 = mon_cyc;
        hold(4'hF, 4'd5, 1'b0, 10);
        check("requal_fall_edge", 32'(last_fall - t0), 32'(5 + LAT));
        check("requal_fall_count", 32'(fall_cnt - f0), 32'd1);
        check("rst_exit_rise", 32'(rise_cnt - r0), 32'd0);
        hold(4'h0, 4'd5, 1'b0, 8);

        rnd_thr = 4'd2;
        for (int r = 0; r < 50; r++) begin
            len = $urandom_range(1, 16);
            sel = $urandom_range(0, 3);
            if (sel == 0)      rnd_i = 4'h0;
            else if (sel == 1) rnd_i = 4'hF;
            else               rnd_i = 4'($urandom);
            if ($urandom_range(0, 2) == 0) rnd_thr = 4'($urandom_range(0, 15));
            for (int j = 0; j < len; j++) begin
                rnd_blank = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) rnd_thr = 4'($urandom_range(0, 6));
                step(rnd_i, rnd_thr, rnd_blank);
            end
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nandn_deglitch.md
NANDN_DEGLITCH -- requirements
Module: nandn_deglitch

Interface
REQ-001 SHALL have parameter N, default 2: number of NAND inputs, legal range 2..8.
REQ-002 SHALL have parameter FILT_W, default 4: width of the qualification threshold and counter.
REQ-003 SHALL have port CELCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CELRSTN, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports CELV, CELG and SUB, each input, 1 bit: supply, ground and substrate ties, no logic function.
REQ-006 SHALL have port i, input, N bits: NAND operands.
REQ-007 SHALL have port thr, input, FILT_W bits: qualification threshold in clocks; 0 is treated as 1.
REQ-008 SHALL have port blank, input, 1 bit: synchronous blanking; freezes o and clears qualification.
REQ-009 SHALL have port o, output, 1 bit: filtered NAND of i.
REQ-010 SHALL have ports rise and fall, each output, 1 bit: single-cycle pulses coincident with o going 0->1 and 1->0.
REQ-011 SHALL have port qual, output, 1 bit: high while in state QUAL.

Function
REQ-012 SHALL compute raw = NOT(AND of all i) and register it into stage s0 every clock.
REQ-013 SHALL implement two states, STABLE and QUAL; "mismatch" means s0 differs from o.
REQ-014 In STABLE with mismatch and blank=0, SHALL set cnt=1 and enter QUAL; if thr is 0 or 1, SHALL instead toggle o and stay in STABLE.
REQ-015 In QUAL with mismatch, SHALL increment cnt; when cnt equals the effective threshold minus 1, SHALL toggle o, clear cnt and return to STABLE.
REQ-016 In QUAL without mismatch, SHALL clear cnt and return to STABLE; o is unchanged (glitch rejected).
REQ-017 A step on i held stable SHALL change o exactly on the (thr_eff+1)th rising edge after the change.
REQ-018 While blank=1, SHALL hold o, force cnt=0 and the state to STABLE; blank has priority over all transitions.
REQ-019 After blank falls with a persistent mismatch, o SHALL toggle on the thr_eff-th edge.
REQ-020 thr SHALL be sampled every cycle; lowering thr below the current cnt SHALL toggle o on the next mismatched edge.
REQ-021 cnt SHALL saturate and never wrap; rise and fall SHALL never be asserted simultaneously.

Reset
REQ-022 On CELRSTN low, SHALL asynchronously set o=1, s0=1, cnt=0, state=STABLE and rise=fall=qual=0.
REQ-023 Reset mid-QUAL SHALL abandon qualification, with no rise or fall pulse on reset exit.

Configuration
REQ-024 With NANDN_DEGLITCH_SYNC_EN defined, each bit of i SHALL pass through a two-flop synchroniser before raw, reset to 0, adding exactly 2 cycles to all input latencies.
REQ-025 Without NANDN_DEGLITCH_SYNC_EN, i SHALL feed raw directly, and behaviour SHALL be exactly as in REQ-012..REQ-021.

Structure
REQ-026 Package nandn_deglitch_pkg SHALL hold the state enum (STABLE, QUAL) and the default N and FILT_W constants.
REQ-027 The synchroniser SHALL be the sub-module nandn_sync, parametrised by width and instantiated only under the macro.

Verification (N=4, FILT_W=4, macro off unless stated)
REQ-028 Reset with i=4'h0: o=1, rise=fall=qual=0, and these values hold throughout the reset.
REQ-029 thr=3, i 4'h0->4'hF held: o falls on the 4th edge, fall is high for exactly that one cycle, and qual is high for the 2 preceding cycles.
REQ-030 thr=3, i=4'hF for 2 cycles then 4'h0: o stays 1, qual pulses and then clears, and rise and fall are never asserted.
REQ-031 thr=3, blank=1 with i=4'hF for 10 cycles: o stays 1; after blank falls, o falls on the 3rd edge.
REQ-032 thr=0, i 4'h0->4'hF: o falls on the 2nd edge; with NANDN_DEGLITCH_SYNC_EN defined, o falls on the 4th edge.
REQ-033 thr=5, CELRSTN pulsed low mid-QUAL: o=1 and qual=0 immediately; requalification takes the full 6 edges.
